// File: rtl/fft_frame_feeder.sv
// Front end of the streaming FFT: buffers free-running real samples, sends one config word, then feeds frame-aligned complex data.
// Build with SAMPLE_DROP_COUNT_EN defined to add the saturating drop_count output and its drop_count_clr input.
module fft_frame_feeder #(
    parameter int          NFFT_LOG2       = 10,
    parameter int          FIFO_DEPTH_LOG2 = 4,
    parameter logic [15:0] CONFIG_WORD     = 16'h0001
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [15:0]          sample_tdata,
    input  logic                 sample_tvalid,
    input  logic                 cfg_restart,
    output logic [15:0]          m_axis_config_tdata,
    output logic                 m_axis_config_tvalid,
    input  logic                 m_axis_config_tready,
    output logic [31:0]          m_axis_data_tdata,
    output logic                 m_axis_data_tvalid,
    input  logic                 m_axis_data_tready,
    output logic                 m_axis_data_tlast,
    output logic [NFFT_LOG2-1:0] frame_idx,
`ifdef SAMPLE_DROP_COUNT_EN
    input  logic                 drop_count_clr,
    output logic [15:0]          drop_count,
`endif
    output logic                 overflow
);

    localparam int                   DEPTH    = 1 << FIFO_DEPTH_LOG2;
    localparam logic [NFFT_LOG2-1:0] LAST_IDX = '1;

    typedef enum logic {ST_CFG, ST_RUN} state_t;

    state_t                     state, state_nxt;
    logic                       cfg_armed;
    logic                       restart_pend, restart_pend_nxt;
    logic                       cfg_hs, pop, push;
    logic                       fifo_empty, fifo_full;
    logic [FIFO_DEPTH_LOG2:0]   wr_ptr, rd_ptr;
    logic signed [15:0]         fifo_mem [DEPTH];
    logic signed [15:0]         fifo_head;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_DEPTH_LOG2] != rd_ptr[FIFO_DEPTH_LOG2]) &&
                        (wr_ptr[FIFO_DEPTH_LOG2-1:0] == rd_ptr[FIFO_DEPTH_LOG2-1:0]);

    // A full FIFO can still take a sample when the head leaves in the same cycle.
    assign push     = sample_tvalid && (!fifo_full || pop);
    assign overflow = sample_tvalid && fifo_full && !pop;

    assign fifo_head           = fifo_mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
    assign m_axis_data_tdata   = {16'h0000, fifo_head};
    assign m_axis_config_tdata = CONFIG_WORD;
    assign m_axis_data_tlast   = m_axis_data_tvalid && (frame_idx == LAST_IDX);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= ST_CFG;
            restart_pend <= 1'b0;
        end else begin
            state        <= state_nxt;
            restart_pend <= restart_pend_nxt;
        end
    end

    always_comb begin
        state_nxt            = state;
        restart_pend_nxt     = restart_pend;
        m_axis_config_tvalid = 1'b0;
        m_axis_data_tvalid   = 1'b0;
        cfg_hs               = 1'b0;
        pop                  = 1'b0;
        case (state)
            ST_CFG: begin
                // The config about to go out already covers any restart request.
                m_axis_config_tvalid = cfg_armed;
                cfg_hs               = cfg_armed && m_axis_config_tready;
                restart_pend_nxt     = 1'b0;
                if (cfg_hs)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                m_axis_data_tvalid = !fifo_empty;
                pop                = m_axis_data_tvalid && m_axis_data_tready;
                if (restart_pend || cfg_restart) begin
                    // At idx 0 only leave when nothing is offered, so valid never drops un-handshaken.
                    if ((pop && frame_idx == LAST_IDX) ||
                        (!m_axis_data_tvalid && frame_idx == '0)) begin
                        state_nxt        = ST_CFG;
                        restart_pend_nxt = 1'b0;
                    end else begin
                        restart_pend_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_CFG;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cfg_armed <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            frame_idx <= '0;
        end else begin
            cfg_armed <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + (FIFO_DEPTH_LOG2+1)'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + (FIFO_DEPTH_LOG2+1)'(1);
                frame_idx <= frame_idx + NFFT_LOG2'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (push)
            fifo_mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= $signed(sample_tdata);
    end

`ifdef SAMPLE_DROP_COUNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            drop_count <= '0;
        else if (drop_count_clr || cfg_hs)
            drop_count <= '0;
        else if (overflow)
            drop_count <= sat_inc16(drop_count);
    end
`endif

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder: config handshake, streaming, overflow, full-with-pop, restart and async reset.
module tb_fft_frame_feeder;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [15:0] sample_tdata;
    logic        sample_tvalid;
    logic        cfg_restart;
    logic [15:0] m_axis_config_tdata;
    logic        m_axis_config_tvalid;
    logic        m_axis_config_tready;
    logic [31:0] m_axis_data_tdata;
    logic        m_axis_data_tvalid;
    logic        m_axis_data_tready;
    logic        m_axis_data_tlast;
    logic [9:0]  frame_idx;
    logic        overflow;
`ifdef SAMPLE_DROP_COUNT_EN
    logic        drop_count_clr;
    logic [15:0] drop_count;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    int hs_count = 0;

    fft_frame_feeder dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .sample_tdata         (sample_tdata),
        .sample_tvalid        (sample_tvalid),
        .cfg_restart          (cfg_restart),
        .m_axis_config_tdata  (m_axis_config_tdata),
        .m_axis_config_tvalid (m_axis_config_tvalid),
        .m_axis_config_tready (m_axis_config_tready),
        .m_axis_data_tdata    (m_axis_data_tdata),
        .m_axis_data_tvalid   (m_axis_data_tvalid),
        .m_axis_data_tready   (m_axis_data_tready),
        .m_axis_data_tlast    (m_axis_data_tlast),
        .frame_idx            (frame_idx),
`ifdef SAMPLE_DROP_COUNT_EN
        .drop_count_clr       (drop_count_clr),
        .drop_count           (drop_count),
`endif
        .overflow             (overflow)
    );

    always #5 aclk = ~aclk;

    // Inputs only change just after a rising edge, so the negedge sees what the next edge will see.
    always @(negedge aclk)
        if (m_axis_config_tvalid && m_axis_config_tready)
            hs_count++;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (m_axis_config_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_valid: got %0b want 0", m_axis_config_tvalid); end
        n_cmp++; if (m_axis_data_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_data_valid: got %0b want 0", m_axis_data_tvalid); end
        n_cmp++; if (m_axis_data_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast: got %0b want 0", m_axis_data_tlast); end
        n_cmp++; if (frame_idx !== 10'd0) begin n_fail++; $display("FAIL rst_frame_idx: got %0d want 0", frame_idx); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %0b want 0", overflow); end
        tick();
        tick();
    endtask

    task automatic test_config();
        #1 aresetn = 1'b1;
        #1;
        n_cmp++; if (m_axis_config_tvalid !== 1'b0) begin n_fail++; $display("FAIL cfg_valid_release: got %0b want 0", m_axis_config_tvalid); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (m_axis_config_tvalid !== 1'b1) begin n_fail++; $display("FAIL cfg_valid_hold[%0d]: got %0b want 1", i, m_axis_config_tvalid); end
            n_cmp++; if (m_axis_config_tdata !== 16'h0001) begin n_fail++; $display("FAIL cfg_tdata[%0d]: got %0h want 0001", i, m_axis_config_tdata); end
            n_cmp++; if (m_axis_data_tvalid !== 1'b0) begin n_fail++; $display("FAIL cfg_data_valid[%0d]: got %0b want 0", i, m_axis_data_tvalid); end
        end
        m_axis_config_tready = 1'b1;
        tick();
        m_axis_config_tready = 1'b0;
        #1;
        n_cmp++; if (m_axis_config_tvalid !== 1'b0) begin n_fail++; $display("FAIL cfg_valid_after_hs: got %0b want 0", m_axis_config_tvalid); end
        n_cmp++; if (hs_count !== 1) begin n_fail++; $display("FAIL cfg_hs_count: got %0d want 1", hs_count); end
    endtask

    task automatic test_stream();
        m_axis_data_tready = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            tick();
            sample_tdata = 16'(i);
            sample_tvalid = 1'b1;
            #1;
            if (i == 0) begin
                n_cmp++; if (m_axis_data_tvalid !== 1'b0) begin n_fail++; $display("FAIL stream_latency: got %0b want 0", m_axis_data_tvalid); end
            end else begin
                n_cmp++; if (m_axis_data_tdata !== {16'h0000, 16'(i - 1)}) begin n_fail++; $display("FAIL stream_data[%0d]: got %0h want %0h", i - 1, m_axis_data_tdata, {16'h0000, 16'(i - 1)}); end
                n_cmp++; if (m_axis_data_tlast !== 1'b0) begin n_fail++; $display("FAIL stream_tlast[%0d]: got %0b want 0", i - 1, m_axis_data_tlast); end
                n_cmp++; if (frame_idx !== 10'(i - 1)) begin n_fail++; $display("FAIL stream_idx[%0d]: got %0d want %0d", i - 1, frame_idx, 10'(i - 1)); end
            end
            if (i == 1024) begin
                n_cmp++; if (m_axis_data_tvalid !== 1'b1) begin n_fail++; $display("FAIL stream_valid1023: got %0b want 1", m_axis_data_tvalid); end
            end
            // Output 1023 (the previous cycle) must have had tlast; re-check it at its own cycle below.
            if (i == 1023) begin
                tick();
                sample_tdata = 16'd1024;
                #1;
                n_cmp++; if (m_axis_data_tlast !== 1'b1) begin n_fail++; $display("FAIL stream_tlast[1023]: got %0b want 1", m_axis_data_tlast); end
                n_cmp++; if (m_axis_data_tdata !== 32'h0000_03FF) begin n_fail++; $display("FAIL stream_data[1023]: got %0h want 3ff", m_axis_data_tdata); end
                i = 1024;
            end
        end
        tick();
        sample_tvalid = 1'b0;
        #1;
        n_cmp++; if (m_axis_data_tdata !== 32'h0000_07FF) begin n_fail++; $display("FAIL stream_data[2047]: got %0h want 7ff", m_axis_data_tdata); end
        n_cmp++; if (m_axis_data_tlast !== 1'b1) begin n_fail++; $display("FAIL stream_tlast[2047]: got %0b want 1", m_axis_data_tlast); end
        tick();
        n_cmp++; if (m_axis_data_tvalid !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got %0b want 0", m_axis_data_tvalid); end
        n_cmp++; if (frame_idx !== 10'd0) begin n_fail++; $display("FAIL stream_wrap: got %0d want 0", frame_idx); end
    endtask

    task automatic test_overflow();
        int ovf;
        ovf = 0;
        m_axis_data_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            sample_tdata = 16'(100 + i);
            sample_tvalid = 1'b1;
            #1;
            if (overflow === 1'b1) ovf++;
            n_cmp++; if (overflow !== (i >= 16)) begin n_fail++; $display("FAIL ovf_pulse[%0d]: got %0b want %0b", i, overflow, (i >= 16)); end
        end
        tick();
        sample_tvalid = 1'b0;
        m_axis_data_tready = 1'b1;
        #1;
        n_cmp++; if (ovf !== 4) begin n_fail++; $display("FAIL ovf_count: got %0d want 4", ovf); end
`ifdef SAMPLE_DROP_COUNT_EN
        n_cmp++; if (drop_count !== 16'd4) begin n_fail++; $display("FAIL drop_count: got %0d want 4", drop_count); end
`endif
        for (int j = 0; j < 16; j++) begin
            n_cmp++; if (m_axis_data_tdata !== {16'h0000, 16'(100 + j)}) begin n_fail++; $display("FAIL ovf_data[%0d]: got %0h want %0h", j, m_axis_data_tdata, {16'h0000, 16'(100 + j)}); end
            tick();
        end
        n_cmp++; if (m_axis_data_tvalid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %0b want 0", m_axis_data_tvalid); end
        n_cmp++; if (frame_idx !== 10'd16) begin n_fail++; $display("FAIL ovf_idx: got %0d want 16", frame_idx); end
`ifdef SAMPLE_DROP_COUNT_EN
        drop_count_clr = 1'b1;
        tick();
        drop_count_clr = 1'b0;
        n_cmp++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL drop_count_clr: got %0d want 0", drop_count); end
`endif
    endtask

    task automatic test_back_to_back();
        m_axis_data_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            sample_tdata = 16'(200 + i);
            sample_tvalid = 1'b1;
        end
        tick();
        sample_tdata = 16'd216;
        m_axis_data_tready = 1'b1;
        #1;
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow: got %0b want 0", overflow); end
        n_cmp++; if (m_axis_data_tdata !== 32'd200) begin n_fail++; $display("FAIL b2b_head: got %0h want c8", m_axis_data_tdata); end
        tick();
        sample_tvalid = 1'b0;
        #1;
        for (int j = 0; j < 16; j++) begin
            n_cmp++; if (m_axis_data_tdata !== {16'h0000, 16'(201 + j)}) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0h want %0h", j, m_axis_data_tdata, {16'h0000, 16'(201 + j)}); end
            tick();
        end
        n_cmp++; if (m_axis_data_tvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %0b want 0", m_axis_data_tvalid); end
        n_cmp++; if (frame_idx !== 10'd33) begin n_fail++; $display("FAIL b2b_idx: got %0d want 33", frame_idx); end
    endtask

    task automatic test_restart();
        for (int k = 0; k < 992; k++) begin
            tick();
            sample_tdata = 16'(k);
            sample_tvalid = 1'b1;
            cfg_restart = (k == 268);
            #1;
            if (k == 268) begin
                n_cmp++; if (frame_idx !== 10'd300) begin n_fail++; $display("FAIL rs_pulse_idx: got %0d want 300", frame_idx); end
            end
            if (k > 0) begin
                n_cmp++; if (m_axis_data_tdata !== {16'h0000, 16'(k - 1)}) begin n_fail++; $display("FAIL rs_data[%0d]: got %0h want %0h", k - 1, m_axis_data_tdata, {16'h0000, 16'(k - 1)}); end
                n_cmp++; if (m_axis_data_tlast !== (k == 991)) begin n_fail++; $display("FAIL rs_tlast[%0d]: got %0b want %0b", k - 1, m_axis_data_tlast, (k == 991)); end
                n_cmp++; if (m_axis_config_tvalid !== 1'b0) begin n_fail++; $display("FAIL rs_cfg_early[%0d]: got %0b want 0", k - 1, m_axis_config_tvalid); end
            end
        end
        tick();
        cfg_restart = 1'b0;
        sample_tdata = 16'd992;
        #1;
        n_cmp++; if (m_axis_config_tvalid !== 1'b1) begin n_fail++; $display("FAIL rs_cfg_valid: got %0b want 1", m_axis_config_tvalid); end
        n_cmp++; if (m_axis_data_tvalid !== 1'b0) begin n_fail++; $display("FAIL rs_data_held: got %0b want 0", m_axis_data_tvalid); end
        n_cmp++; if (frame_idx !== 10'd0) begin n_fail++; $display("FAIL rs_idx_wrap: got %0d want 0", frame_idx); end
        tick();
        sample_tdata = 16'd993;
        tick();
        sample_tvalid = 1'b0;
        m_axis_config_tready = 1'b1;
        tick();
        m_axis_config_tready = 1'b0;
        #1;
        n_cmp++; if (hs_count !== 2) begin n_fail++; $display("FAIL rs_hs_count: got %0d want 2", hs_count); end
        n_cmp++; if (m_axis_data_tvalid !== 1'b1) begin n_fail++; $display("FAIL rs_resume_valid: got %0b want 1", m_axis_data_tvalid); end
        for (int j = 0; j < 3; j++) begin
            n_cmp++; if (m_axis_data_tdata !== {16'h0000, 16'(991 + j)}) begin n_fail++; $display("FAIL rs_resume_data[%0d]: got %0h want %0h", j, m_axis_data_tdata, {16'h0000, 16'(991 + j)}); end
            n_cmp++; if (frame_idx !== 10'(j)) begin n_fail++; $display("FAIL rs_resume_idx[%0d]: got %0d want %0d", j, frame_idx, j); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 497; k++) begin
            tick();
            sample_tdata = 16'(16'h2000 + k);
            sample_tvalid = 1'b1;
        end
        tick();
        sample_tvalid = 1'b0;
        tick();
        m_axis_data_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sample_tdata = 16'(16'h3000 + i);
            sample_tvalid = 1'b1;
            tick();
        end
        sample_tvalid = 1'b0;
        #1;
        n_cmp++; if (frame_idx !== 10'd500) begin n_fail++; $display("FAIL ar_pre_idx: got %0d want 500", frame_idx); end
        n_cmp++; if (m_axis_data_tdata !== 32'h0000_3000) begin n_fail++; $display("FAIL ar_pre_head: got %0h want 3000", m_axis_data_tdata); end
        #2 aresetn = 1'b0;
        #1;
        n_cmp++; if (m_axis_data_tvalid !== 1'b0) begin n_fail++; $display("FAIL ar_data_valid: got %0b want 0", m_axis_data_tvalid); end
        n_cmp++; if (frame_idx !== 10'd0) begin n_fail++; $display("FAIL ar_idx: got %0d want 0", frame_idx); end
        n_cmp++; if (m_axis_data_tlast !== 1'b0) begin n_fail++; $display("FAIL ar_tlast: got %0b want 0", m_axis_data_tlast); end
        n_cmp++; if (m_axis_config_tvalid !== 1'b0) begin n_fail++; $display("FAIL ar_cfg_valid: got %0b want 0", m_axis_config_tvalid); end
        tick();
        tick();
        #1 aresetn = 1'b1;
        tick();
        n_cmp++; if (m_axis_config_tvalid !== 1'b1) begin n_fail++; $display("FAIL ar_cfg_resend: got %0b want 1", m_axis_config_tvalid); end
        n_cmp++; if (m_axis_data_tvalid !== 1'b0) begin n_fail++; $display("FAIL ar_empty: got %0b want 0", m_axis_data_tvalid); end
        sample_tdata = 16'h8000;
        sample_tvalid = 1'b1;
        tick();
        sample_tdata = 16'h0005;
        tick();
        sample_tvalid = 1'b0;
        m_axis_config_tready = 1'b1;
        tick();
        m_axis_config_tready = 1'b0;
        m_axis_data_tready = 1'b1;
        #1;
        n_cmp++; if (hs_count !== 3) begin n_fail++; $display("FAIL ar_hs_count: got %0d want 3", hs_count); end
        n_cmp++; if (m_axis_data_tdata !== 32'h0000_8000) begin n_fail++; $display("FAIL ar_first_data: got %0h want 00008000", m_axis_data_tdata); end
        n_cmp++; if (frame_idx !== 10'd0) begin n_fail++; $display("FAIL ar_first_idx: got %0d want 0", frame_idx); end
        tick();
        n_cmp++; if (m_axis_data_tdata !== 32'h0000_0005) begin n_fail++; $display("FAIL ar_second_data: got %0h want 5", m_axis_data_tdata); end
        n_cmp++; if (frame_idx !== 10'd1) begin n_fail++; $display("FAIL ar_second_idx: got %0d want 1", frame_idx); end
        tick();
        n_cmp++; if (m_axis_data_tvalid !== 1'b0) begin n_fail++; $display("FAIL ar_drained: got %0b want 0", m_axis_data_tvalid); end
    endtask

    initial begin
        aresetn = 1'b0;
        sample_tdata = '0;
        sample_tvalid = 1'b0;
        cfg_restart = 1'b0;
        m_axis_config_tready = 1'b0;
        m_axis_data_tready = 1'b0;
`ifdef SAMPLE_DROP_COUNT_EN
        drop_count_clr = 1'b0;
`endif
        test_reset();
        test_config();
        test_stream();
        test_overflow();
        test_back_to_back();
        test_restart();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
